rc4_encrypt_core: RTL and testbench



---
 rtl/rc4_pkg.sv | 52 +++++
 rtl/rc4_swap_unit.sv | 61 ++++++
 rtl/rc4_encrypt_core.sv | 187 ++++++++++++++++++
 tb/tb_rc4_encrypt_core.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types for the RC4 encryption core: FSM states, swap phases
// and key byte selection.
package rc4_pkg;

   localparam int KEY_BYTES = 3;

   typedef logic [7:0] byte_t;

   typedef enum logic [4:0] {
      IDLE,
      INIT,
      KSA_RD_I,
      KSA_WT_I,
      KSA_RD_J,
      KSA_WT_J,
      KSA_WR_I,
      KSA_WR_J,
      P_RD_I,
      P_WT_I,
      P_RD_J,
      P_WT_J,
      P_WR_I,
      P_WR_J,
      P_RD_F,
      P_WT_F,
      P_WR_C,
      DONE
   } state_t;

   typedef enum logic [2:0] {
      SW_NONE,
      SW_RD_I,
      SW_WT_I,
      SW_RD_J,
      SW_WT_J,
      SW_WR_I,
      SW_WR_J
   } swap_ph_t;

   // byte0 is the most significant byte of the 24-bit key
   function automatic byte_t key_byte(
      input logic [8*KEY_BYTES-1:0] key,
      input logic [1:0]             idx
   );
      case (idx)
         2'd0:    return key[23:16];
         2'd1:    return key[15:8];
         default: return key[7:0];
      endcase
   endfunction

endpackage

// File: rtl/rc4_swap_unit.sv
// Read S[i], read S[j], write swapped values back; owns j, si and sj.
// Shared by the KSA and PRGA phases of rc4_encrypt_core.
module rc4_swap_unit
   import rc4_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  swap_ph_t ph,
   input  byte_t    i,
   input  byte_t    j_add,
   input  logic     j_clr,
   input  byte_t    s_q,
   output byte_t    si,
   output byte_t    sj,
   output byte_t    s_address,
   output byte_t    s_data,
   output logic     s_wren
);

   byte_t j;

   // RAM data is captured as each wait state exits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         j  <= '0;
         si <= '0;
         sj <= '0;
      end else begin
         if (j_clr)
            j <= '0;
         else if (ph == SW_WT_I)
            j <= j + s_q + j_add;
         if (ph == SW_WT_I)
            si <= s_q;
         if (ph == SW_WT_J)
            sj <= s_q;
      end
   end

   always_comb begin
      s_address = '0;
      s_data    = '0;
      s_wren    = 1'b0;
      case (ph)
         SW_RD_I, SW_WT_I: s_address = i;
         SW_RD_J, SW_WT_J: s_address = j;
         SW_WR_I: begin
            s_address = i;
            s_data    = sj;
            s_wren    = 1'b1;
         end
         SW_WR_J: begin
            s_address = j;
            s_data    = si;
            s_wren    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rc4_encrypt_core.sv
// RC4 encryption engine: identity init, KSA and PRGA on an external S-RAM.
// Optional RC4_CHECKSUM_EN adds ct_checksum, the XOR of this run's ciphertext.
module rc4_encrypt_core
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = 32,
   parameter int MSG_AW  = 5
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [23:0]       secret_key,
   output logic              busy,
   output logic              done,
   output logic [7:0]        s_address,
   output logic [7:0]        s_data,
   output logic              s_wren,
   input  logic [7:0]        s_q,
   output logic [MSG_AW-1:0] pt_address,
   input  logic [7:0]        pt_q,
   output logic [MSG_AW-1:0] ct_address,
   output logic [7:0]        ct_data,
   output logic              ct_wren
`ifdef RC4_CHECKSUM_EN
   ,
   output logic [7:0]        ct_checksum
`endif
);

   localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

   state_t              state;
   state_t              state_nxt;
   byte_t               i;
   logic [MSG_AW-1:0]   k;
   logic [23:0]         key;
   byte_t               ct_byte;

   swap_ph_t            ph;
   logic                in_ksa;
   logic [1:0]          kidx;
   byte_t               sw_i;
   byte_t               j_add;
   logic                j_clr;
   byte_t               si;
   byte_t               sj;
   byte_t               sw_address;
   byte_t               sw_data;
   logic                sw_wren;

   assign in_ksa = state inside {KSA_RD_I, KSA_WT_I, KSA_RD_J,
                                 KSA_WT_J, KSA_WR_I, KSA_WR_J};
   assign kidx   = 2'(i % 8'd3);
   assign j_add  = in_ksa ? key_byte(key, kidx) : 8'd0;
   assign sw_i   = (state == P_RD_I) ? i + 8'd1 : i;
   assign j_clr  = (state == IDLE) || (state == INIT) ||
                   ((state == KSA_WR_J) && (i == 8'hFF));

   always_comb begin
      ph = SW_NONE;
      case (state)
         KSA_RD_I, P_RD_I: ph = SW_RD_I;
         KSA_WT_I, P_WT_I: ph = SW_WT_I;
         KSA_RD_J, P_RD_J: ph = SW_RD_J;
         KSA_WT_J, P_WT_J: ph = SW_WT_J;
         KSA_WR_I, P_WR_I: ph = SW_WR_I;
         KSA_WR_J, P_WR_J: ph = SW_WR_J;
         default:          ph = SW_NONE;
      endcase
   end

   rc4_swap_unit u_swap (
      .clk       (clk),
      .reset     (reset),
      .ph        (ph),
      .i         (sw_i),
      .j_add     (j_add),
      .j_clr     (j_clr),
      .s_q       (s_q),
      .si        (si),
      .sj        (sj),
      .s_address (sw_address),
      .s_data    (sw_data),
      .s_wren    (sw_wren)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i       <= '0;
         k       <= '0;
         key     <= '0;
         ct_byte <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  key <= secret_key;
                  i   <= '0;
                  k   <= '0;
               end
            end
            INIT, KSA_WR_J, P_RD_I: i <= i + 8'd1;
            P_WT_F:  ct_byte <= s_q ^ pt_q;
            P_WR_C:  k <= k + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start) state_nxt = INIT;
         INIT:     if (i == 8'hFF) state_nxt = KSA_RD_I;
         KSA_RD_I: state_nxt = KSA_WT_I;
         KSA_WT_I: state_nxt = KSA_RD_J;
         KSA_RD_J: state_nxt = KSA_WT_J;
         KSA_WT_J: state_nxt = KSA_WR_I;
         KSA_WR_I: state_nxt = KSA_WR_J;
         KSA_WR_J: state_nxt = (i == 8'hFF) ? P_RD_I : KSA_RD_I;
         P_RD_I:   state_nxt = P_WT_I;
         P_WT_I:   state_nxt = P_RD_J;
         P_RD_J:   state_nxt = P_WT_J;
         P_WT_J:   state_nxt = P_WR_I;
         P_WR_I:   state_nxt = P_WR_J;
         P_WR_J:   state_nxt = P_RD_F;
         P_RD_F:   state_nxt = P_WT_F;
         P_WT_F:   state_nxt = P_WR_C;
         P_WR_C:   state_nxt = (k == K_LAST) ? DONE : P_RD_I;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      done       = (state == DONE);
      s_address  = '0;
      s_data     = '0;
      s_wren     = 1'b0;
      pt_address = '0;
      ct_address = '0;
      ct_data    = '0;
      ct_wren    = 1'b0;
      unique case (1'b1)
         state == INIT: begin
            s_address = i;
            s_data    = i;
            s_wren    = 1'b1;
         end
         (state == P_RD_F) || (state == P_WT_F): begin
            s_address  = si + sj;
            pt_address = k;
         end
         state == P_WR_C: begin
            ct_address = k;
            ct_data    = ct_byte;
            ct_wren    = 1'b1;
         end
         default: begin
            s_address = sw_address;
            s_data    = sw_data;
            s_wren    = sw_wren;
         end
      endcase
   end

`ifdef RC4_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ct_checksum <= '0;
      else if ((state == IDLE) && start)
         ct_checksum <= '0;
      else if (state == P_WR_C)
         ct_checksum <= ct_checksum ^ ct_byte;
   end
`endif

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// Bench for rc4_encrypt_core: known RC4 vectors plus a plain-array RC4
// reference model for random keys and plaintexts.
module tb_rc4_encrypt_core;

   localparam int N      = 9;
   localparam int AW     = 4;
   localparam int LAT    = 1793 + 9 * N;
   localparam int SWR    = 256 + 2 * 256 + 2 * N;
   localparam int BUDGET = 4000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [23:0]   secret_key = '0;
   logic          busy;
   logic          done;
   logic [7:0]    s_address;
   logic [7:0]    s_data;
   logic          s_wren;
   logic [7:0]    s_q;
   logic [AW-1:0] pt_address;
   logic [7:0]    pt_q;
   logic [AW-1:0] ct_address;
   logic [7:0]    ct_data;
   logic          ct_wren;
`ifdef RC4_CHECKSUM_EN
   logic [7:0]    ct_checksum;
`endif

   logic [7:0] smem [256];
   logic [7:0] ptm [16];
   logic [7:0] ctm [16];
   logic [7:0] exp_ct [N];

   int n_checks  = 0;
   int n_fail    = 0;
   int done_cnt  = 0;
   int ct_writes = 0;
   int s_writes  = 0;

   always #5 clk = ~clk;

   rc4_encrypt_core #(.MSG_LEN(N), .MSG_AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .secret_key (secret_key),
      .busy       (busy),
      .done       (done),
      .s_address  (s_address),
      .s_data     (s_data),
      .s_wren     (s_wren),
      .s_q        (s_q),
      .pt_address (pt_address),
      .pt_q       (pt_q),
      .ct_address (ct_address),
      .ct_data    (ct_data),
      .ct_wren    (ct_wren)
`ifdef RC4_CHECKSUM_EN
      ,
      .ct_checksum(ct_checksum)
`endif
   );

   always @(posedge clk) begin
      if (s_wren) smem[s_address] <= s_data;
      s_q  <= smem[s_address];
      pt_q <= ptm[pt_address];
      if (ct_wren) ctm[ct_address] <= ct_data;
   end

   always @(posedge clk) begin
      if (done) done_cnt++;
      if (ct_wren) ct_writes++;
      if (s_wren) s_writes++;
   end

   // Textbook RC4 over plain int arrays
   task automatic rc4_ref(input logic [23:0] key);
      int s [256];
      int j, t, ii, ks, kb;
      for (int x = 0; x < 256; x++) s[x] = x;
      j = 0;
      for (int x = 0; x < 256; x++) begin
         kb = int'(key >> (8 * (2 - (x % 3)))) & 255;
         j = (j + s[x] + kb) % 256;
         t = s[x]; s[x] = s[j]; s[j] = t;
      end
      ii = 0;
      j  = 0;
      for (int n = 0; n < N; n++) begin
         ii = (ii + 1) % 256;
         j  = (j + s[ii]) % 256;
         t = s[ii]; s[ii] = s[j]; s[j] = t;
         ks = s[(s[ii] + s[j]) % 256];
         exp_ct[n] = ptm[n] ^ ks[7:0];
      end
   endtask

   task automatic clear_ct();
      for (int n = 0; n < 16; n++) ctm[n] = 'x;
   endtask

   task automatic rand_pt();
      for (int n = 0; n < 16; n++) ptm[n] = 8'($urandom);
   endtask

   task automatic run_enc(input logic [23:0] key, output int lat);
      int c;
      @(negedge clk);
      secret_key = key;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      secret_key = 24'($urandom);
      c = 1;
      while (done !== 1'b1 && c < BUDGET) begin
         @(negedge clk);
         c++;
      end
      lat = (done === 1'b1) ? c : -1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, s_wren, ct_wren, s_address, s_data,
           pt_address, ct_address, ct_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b s_addr=%0h ct_addr=%0h required all 0",
                  busy, done, s_address, ct_address);
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done_cnt !== 0) begin
         n_fail++;
         $display("FAIL idle_quiet: busy=%b dones=%0d required 0/0", busy, done_cnt);
      end
   endtask

   task automatic test_known_vectors();
      logic [8*N-1:0] pt_str;
      logic [8*N-1:0] ct_kv;
      logic [8*N-1:0] ks_kv;
      int lat;
      int w0, sw0;
      pt_str = "Plaintext";
      ct_kv  = 72'hBBF316E8D940AF0AD3;
      ks_kv  = 72'hEB9F7781B734CA72A7;
      for (int n = 0; n < N; n++) ptm[n] = pt_str[8*(N-1-n) +: 8];
      clear_ct();
      w0  = ct_writes;
      sw0 = s_writes;
      run_enc(24'h4B6579, lat);
      n_checks++;
      if (lat !== LAT) begin
         n_fail++;
         $display("FAIL latency_plaintext: got %0d required %0d", lat, LAT);
      end
      for (int n = 0; n < N; n++) begin
         n_checks++;
         if (ctm[n] !== ct_kv[8*(N-1-n) +: 8]) begin
            n_fail++;
            $display("FAIL ct_plaintext[%0d]: got %h required %h",
                     n, ctm[n], ct_kv[8*(N-1-n) +: 8]);
         end
      end
      n_checks++;
      if (ct_writes - w0 !== N || s_writes - sw0 !== SWR) begin
         n_fail++;
         $display("FAIL write_counts: ct=%0d s=%0d required %0d/%0d",
                  ct_writes - w0, s_writes - sw0, N, SWR);
      end
      for (int n = 0; n < 16; n++) ptm[n] = 8'h00;
      clear_ct();
      run_enc(24'h4B6579, lat);
      for (int n = 0; n < N; n++) begin
         n_checks++;
         if (ctm[n] !== ks_kv[8*(N-1-n) +: 8]) begin
            n_fail++;
            $display("FAIL keystream[%0d]: got %h required %h",
                     n, ctm[n], ks_kv[8*(N-1-n) +: 8]);
         end
      end
   endtask

   task automatic test_roundtrip();
      logic [7:0] orig [N];
      logic [23:0] key;
      int lat;
      key = 24'($urandom);
      rand_pt();
      for (int n = 0; n < N; n++) orig[n] = ptm[n];
      clear_ct();
      run_enc(key, lat);
      for (int n = 0; n < N; n++) ptm[n] = ctm[n];
      clear_ct();
      run_enc(key, lat);
      n_checks++;
      if (lat !== LAT) begin
         n_fail++;
         $display("FAIL latency_roundtrip: got %0d required %0d", lat, LAT);
      end
      for (int n = 0; n < N; n++) begin
         n_checks++;
         if (ctm[n] !== orig[n]) begin
            n_fail++;
            $display("FAIL roundtrip[%0d]: got %h required %h", n, ctm[n], orig[n]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      logic [23:0] key_a;
      int c, d0;
      key_a = 24'($urandom);
      rand_pt();
      rc4_ref(key_a);
      clear_ct();
      repeat (3) @(negedge clk);
      d0 = done_cnt;
      secret_key = key_a;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (done !== 1'b1 && c < BUDGET) begin
         @(negedge clk);
         c++;
         if (c == 95) begin
            secret_key = ~key_a;
            start      = 1'b1;
         end else if (c == 96) begin
            start = 1'b0;
         end else if (c == 500) begin
            secret_key = 24'($urandom);
         end
      end
      n_checks++;
      if (c !== LAT) begin
         n_fail++;
         $display("FAIL latency_busy_start: got %0d required %0d", c, LAT);
      end
      repeat (40) @(negedge clk);
      for (int n = 0; n < N; n++) begin
         n_checks++;
         if (ctm[n] !== exp_ct[n]) begin
            n_fail++;
            $display("FAIL busy_start_ct[%0d]: got %h required %h", n, ctm[n], exp_ct[n]);
         end
      end
      n_checks++;
      if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_done: dones=%0d busy=%b required 1/0",
                  done_cnt - d0, busy);
      end
   endtask

   task automatic test_reset_mid_prga();
      logic [23:0] key;
      int c, d0, lat;
      rand_pt();
      @(negedge clk);
      secret_key = 24'($urandom);
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (c < 1820) begin
         @(negedge clk);
         c++;
      end
      d0    = done_cnt;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, s_wren, ct_wren, s_address, s_data,
           pt_address, ct_address, ct_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_prga: busy=%b s_wren=%b ct_wren=%b s_addr=%0h required all 0",
                  busy, s_wren, ct_wren, s_address);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      n_checks++;
      if (done_cnt !== d0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_done: dones=%0d busy=%b required 0/0",
                  done_cnt - d0, busy);
      end
      key = 24'($urandom);
      rc4_ref(key);
      clear_ct();
      run_enc(key, lat);
      n_checks++;
      if (lat !== LAT) begin
         n_fail++;
         $display("FAIL latency_after_reset: got %0d required %0d", lat, LAT);
      end
      for (int n = 0; n < N; n++) begin
         n_checks++;
         if (ctm[n] !== exp_ct[n]) begin
            n_fail++;
            $display("FAIL after_reset_ct[%0d]: got %h required %h", n, ctm[n], exp_ct[n]);
         end
      end
   endtask

   task automatic test_random();
      logic [23:0] key;
      int lat;
      for (int r = 0; r < 3; r++) begin
         key = 24'($urandom);
         rand_pt();
         rc4_ref(key);
         clear_ct();
         run_enc(key, lat);
         n_checks++;
         if (lat !== LAT) begin
            n_fail++;
            $display("FAIL latency_random%0d: got %0d required %0d", r, lat, LAT);
         end
         for (int n = 0; n < N; n++) begin
            n_checks++;
            if (ctm[n] !== exp_ct[n]) begin
               n_fail++;
               $display("FAIL random%0d_ct[%0d]: got %h required %h",
                        r, n, ctm[n], exp_ct[n]);
            end
         end
      end
   endtask

`ifdef RC4_CHECKSUM_EN
   task automatic test_checksum();
      logic [8*N-1:0] pt_str;
      logic [7:0] x;
      int lat;
      pt_str = "Plaintext";
      for (int n = 0; n < N; n++) ptm[n] = pt_str[8*(N-1-n) +: 8];
      rc4_ref(24'h4B6579);
      x = 8'h00;
      for (int n = 0; n < N; n++) x = x ^ exp_ct[n];
      run_enc(24'h4B6579, lat);
      repeat (3) @(negedge clk);
      n_checks++;
      if (ct_checksum !== x) begin
         n_fail++;
         $display("FAIL checksum_hold: got %h required %h", ct_checksum, x);
      end
      secret_key = 24'h123456;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (ct_checksum !== 8'h00) begin
         n_fail++;
         $display("FAIL checksum_clear: got %h required 00", ct_checksum);
      end
      while (done !== 1'b1 && lat < 2 * BUDGET) begin
         @(negedge clk);
         lat++;
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      for (int a = 0; a < 256; a++) smem[a] = 8'($urandom);
      for (int n = 0; n < 16; n++) ptm[n] = 8'h00;
      test_reset();
      test_known_vectors();
      test_roundtrip();
      test_start_while_busy();
      test_reset_mid_prga();
      test_random();
`ifdef RC4_CHECKSUM_EN
      test_checksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
